// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b LSB first through one full-subtractor
// cell and a borrow flip-flop, then publishes diff/borrow/ovf with a one-cycle done pulse.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_bf;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_busy;
    logic             r_done;
    logic             r_borrow;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic             w_d;
    logic             w_bf_nxt;

    // Full-subtractor cell on the current LSBs
    assign w_d      = r_sa[0] ^ r_sb[0] ^ r_bf;
    assign w_bf_nxt = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_bf);
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand shifting, borrow tracking and result publication
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa     <= '0;
            r_sb     <= '0;
            r_res    <= '0;
            r_diff   <= '0;
            r_cnt    <= '0;
            r_bf     <= 1'b0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        r_bf    <= 1'b0;
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_res <= {w_d, r_res[WIDTH-1:1]};
                    r_bf  <= w_bf_nxt;
                    r_cnt <= r_cnt + CW'(1);
                end
                S_FIN: begin
                    r_diff   <= r_res;
                    r_borrow <= r_bf;
                    r_ovf    <= (r_a_msb ^ r_b_msb) & (r_res[WIDTH-1] ^ r_a_msb);
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign diff   = r_diff;
    assign borrow = r_borrow;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed and random operands checked
// against an arithmetic reference model, plus start-ignore, back-to-back and async reset.
module tb_serial_subtractor;

    localparam int unsigned W = 4;
    localparam int HALF = 1 << (W - 1);
    localparam int FULL = 1 << W;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;

    int checks   = 0;
    int failures = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference: {diff, borrow, ovf} from plain integer arithmetic
    function automatic logic [W+1:0] model(input logic [W-1:0] ia, input logic [W-1:0] ib);
        int ua, ub, sa, sb, r;
        logic [W-1:0] d;
        logic bo, ov;
        ua = int'(ia);
        ub = int'(ib);
        d  = W'(ua - ub + FULL);
        bo = (ua < ub);
        sa = (ua >= HALF) ? ua - FULL : ua;
        sb = (ub >= HALF) ? ub - FULL : ub;
        r  = sa - sb;
        ov = (r > HALF - 1) || (r < -HALF);
        return {d, bo, ov};
    endfunction

    // Issue one operation from IDLE; returns clocks to done and busy-cycle count
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          output int lat, output int bcnt);
        @(negedge clk);
        a = ia; b = ib; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        lat = -1;
        bcnt = 0;
        for (int k = 1; k <= 20; k++) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, diff, borrow, ovf} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0", {busy, done, diff, borrow, ovf});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int lat, bcnt;
        logic [W+1:0] exp;
        run_op(4'd9, 4'd3, lat, bcnt);
        exp = model(4'd9, 4'd3);
        checks++;
        if (lat !== 5) begin
            failures++; $display("FAIL basic_latency got=%0d exp=5", lat);
        end
        checks++;
        if (bcnt !== 5) begin
            failures++; $display("FAIL basic_busy_cycles got=%0d exp=5", bcnt);
        end
        checks++;
        if ({diff, borrow, ovf} !== exp) begin
            failures++; $display("FAIL basic_result got=%b exp=%b", {diff, borrow, ovf}, exp);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || {diff, borrow, ovf} !== exp) begin
            failures++; $display("FAIL basic_pulse_hold done=%b res=%b exp_res=%b", done, {diff, borrow, ovf}, exp);
        end
    endtask

    task automatic test_table;
        int lat, bcnt;
        logic [2*W-1:0] op;
        logic [W+1:0] exp;
        for (int i = 0; i < 24; i++) begin
            case (i)
                0: op = {4'd15, 4'd15};
                1: op = {4'd0,  4'd0};
                2: op = {4'd0,  4'd15};
                3: op = {4'd3,  4'd9};
                4: op = {4'd8,  4'd1};
                5: op = {4'd5,  4'd0};
                6: op = {4'd7,  4'd8};
                7: op = {4'd8,  4'd7};
                default: op = (2*W)'($urandom);
            endcase
            run_op(op[2*W-1:W], op[W-1:0], lat, bcnt);
            exp = model(op[2*W-1:W], op[W-1:0]);
            checks++;
            if (lat !== 5) begin
                failures++; $display("FAIL table_latency[%0d] got=%0d exp=5", i, lat);
            end
            checks++;
            if ({diff, borrow, ovf} !== exp) begin
                failures++;
                $display("FAIL table_result[%0d] a=%0d b=%0d got=%b exp=%b",
                         i, op[2*W-1:W], op[W-1:0], {diff, borrow, ovf}, exp);
            end
        end
    endtask

    task automatic test_ignore_busy;
        int bcnt, dcnt, first;
        logic [W+1:0] exp;
        exp = model(4'd9, 4'd3);
        @(negedge clk);
        a = 4'd9; b = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = 4'd1; b = 4'd1;
        bcnt = busy ? 1 : 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (busy) bcnt++;
        dcnt = 0; first = -1;
        for (int k = 2; k <= 14; k++) begin
            @(posedge clk); #1;
            if (busy) bcnt++;
            if (done) begin
                dcnt++;
                if (first < 0) first = k;
            end
        end
        checks++;
        if (dcnt !== 1 || first !== 5) begin
            failures++; $display("FAIL ignore_done_count got=%0d at=%0d exp=1 at=5", dcnt, first);
        end
        checks++;
        if (bcnt !== 5) begin
            failures++; $display("FAIL ignore_busy_cycles got=%0d exp=5", bcnt);
        end
        checks++;
        if ({diff, borrow, ovf} !== exp) begin
            failures++; $display("FAIL ignore_result got=%b exp=%b", {diff, borrow, ovf}, exp);
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] oa [6];
        logic [W-1:0] ob [6];
        logic [W+1:0] prev, exp;
        logic held_ok;
        int c;
        oa[0] = 4'd9;  ob[0] = 4'd3;
        oa[1] = 4'd3;  ob[1] = 4'd9;
        oa[2] = 4'd8;  ob[2] = 4'd1;
        oa[3] = 4'd12; ob[3] = 4'd5;
        oa[4] = 4'd9;  ob[4] = 4'd3;
        oa[5] = 4'd3;  ob[5] = 4'd9;
        held_ok = 1'b1;
        prev = '0;
        @(negedge clk);
        a = oa[0]; b = ob[0]; start = 1'b1;
        @(posedge clk); #1;
        a = oa[1]; b = ob[1];
        c = 0;
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 20; k++) begin
                @(posedge clk); #1;
                c++;
                if (done) break;
                if (i > 0 && {diff, borrow, ovf} !== prev) held_ok = 1'b0;
            end
            exp = model(oa[i], ob[i]);
            checks++;
            if (c !== ((i == 0) ? 5 : 6)) begin
                failures++; $display("FAIL b2b_interval[%0d] got=%0d exp=%0d", i, c, (i == 0) ? 5 : 6);
            end
            checks++;
            if ({diff, borrow, ovf} !== exp) begin
                failures++; $display("FAIL b2b_result[%0d] got=%b exp=%b", i, {diff, borrow, ovf}, exp);
            end
            prev = exp;
            if (i == 5) begin
                start = 1'b0;
            end else begin
                @(posedge clk); #1;
                c = 1;
                if ({diff, borrow, ovf} !== prev) held_ok = 1'b0;
                if (i + 2 < 6) begin
                    a = oa[i+2]; b = ob[i+2];
                end
            end
        end
        checks++;
        if (held_ok !== 1'b1) begin
            failures++; $display("FAIL b2b_hold got=%b exp=1", held_ok);
        end
    endtask

    task automatic test_async_reset;
        int lat, bcnt;
        logic seen;
        @(negedge clk);
        a = 4'd12; b = 4'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, diff, borrow, ovf} !== '0) begin
            failures++; $display("FAIL async_reset_outputs got=%b exp=0", {busy, done, diff, borrow, ovf});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++; $display("FAIL post_reset_quiet got=%b exp=0", seen);
        end
        run_op(4'd12, 4'd5, lat, bcnt);
        checks++;
        if (lat !== 5 || {diff, borrow, ovf} !== model(4'd12, 4'd5)) begin
            failures++;
            $display("FAIL post_reset_op lat=%0d got=%b exp=%b", lat, {diff, borrow, ovf}, model(4'd12, 4'd5));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_table();
        test_ignore_busy();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
